// File: rtl/queue_arb_pkg.sv
// queue_arb_pkg: shared defaults, widths and width helpers for the
// round-robin enqueue arbiter (queue_arb) and its picker (rr_pick).
//   NREQ_DEFAULT  - number of producers
//   DW_DEFAULT    - payload width
//   DEPTH_DEFAULT - downstream queue capacity in entries
//   OCC_W / occ_t - occupancy counter width/type for the default depth
//   PTR_W / ptr_t - round-robin pointer width/type for the default NREQ
package queue_arb_pkg;

    localparam int NREQ_DEFAULT  = 4;
    localparam int DW_DEFAULT    = 32;
    localparam int DEPTH_DEFAULT = 8;

    localparam int OCC_W = $clog2(DEPTH_DEFAULT + 1);
    localparam int PTR_W = $clog2(NREQ_DEFAULT);

    typedef logic [OCC_W-1:0] occ_t;
    typedef logic [PTR_W-1:0] ptr_t;

    // Pointer width for n producers; a single producer still needs one bit.
    function automatic int ptr_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Counter width able to hold 0..depth inclusive.
    function automatic int occ_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/rr_pick.sv
// rr_pick: combinational round-robin search.
// Picks the first requester at or after ptr, wrapping modulo NREQ.
//   req   in  NREQ  request vector (already qualified by the caller)
//   ptr   in  PW    search start position
//   gnt   out NREQ  one-hot winner (all-zero when no request)
//   index out PW    binary index of the winner (0 when no request)
module rr_pick
    import queue_arb_pkg::*;
#(
    parameter int NREQ = NREQ_DEFAULT,
    parameter int PW   = ptr_width(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [PW-1:0]   ptr,
    output logic [NREQ-1:0] gnt,
    output logic [PW-1:0]   index
);

    logic found_s;
    logic hit_s;

    // Two passes: first the positions at/above ptr, then the wrapped
    // positions below it. Anything at/above ptr was already considered in
    // the first pass, so the second pass only ever hits the wrap region.
    always_comb begin
        gnt     = {NREQ{1'b0}};
        index   = {PW{1'b0}};
        found_s = 1'b0;
        hit_s   = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            hit_s   = req[i] && (PW'(i) >= ptr) && !found_s;
            gnt[i]  = hit_s;
            index   = hit_s ? PW'(i) : index;
            found_s = found_s | hit_s;
        end
        for (int i = 0; i < NREQ; i++) begin
            hit_s   = req[i] && !found_s;
            gnt[i]  = gnt[i] | hit_s;
            index   = hit_s ? PW'(i) : index;
            found_s = found_s | hit_s;
        end
    end

endmodule

// File: rtl/queue_arb.sv
// queue_arb: round-robin arbiter feeding a downstream queue of DEPTH entries.
// Tracks queue occupancy itself (counting a grant immediately, i.e. including
// the enqueue still in flight) and withholds grants while the queue is full.
//   clk, rst  in   clock, asynchronous active-high reset
//   req       in   NREQ      per-producer enqueue request (level)
//   data      in   NREQ*DW   payloads, producer i at [i*DW +: DW]
//   gnt       out  NREQ      one-hot grant (combinational)
//   q_enq     out  1         registered enqueue strobe
//   q_din     out  DW        registered enqueue payload (holds when idle)
//   q_full    in   1         queue full flag (not used for control)
//   q_empty   in   1         queue empty flag
//   c_deq     in   1         consumer dequeue request
//   q_deq     out  1         dequeue strobe (combinational)
//   occ       out  OW        tracked occupancy 0..DEPTH
//   stall     out  1         registered full indication
module queue_arb
    import queue_arb_pkg::*;
#(
    parameter int NREQ  = NREQ_DEFAULT,
    parameter int DW    = DW_DEFAULT,
    parameter int DEPTH = DEPTH_DEFAULT
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NREQ-1:0]               req,
    input  logic [NREQ*DW-1:0]            data,
    output logic [NREQ-1:0]               gnt,
    output logic                          q_enq,
    output logic [DW-1:0]                 q_din,
    input  logic                          q_full,
    input  logic                          q_empty,
    input  logic                          c_deq,
    output logic                          q_deq,
    output logic [occ_width(DEPTH)-1:0]   occ,
    output logic                          stall
);

    localparam int OW = occ_width(DEPTH);
    localparam int PW = ptr_width(NREQ);
    localparam logic [OW-1:0] OCC_FULL = OW'(DEPTH);
    localparam logic [PW-1:0] PTR_LAST = PW'(NREQ - 1);

    logic [PW-1:0]   rr_ptr_r;
    logic [OW-1:0]   occ_r;
    logic            q_enq_r;
    logic [DW-1:0]   q_din_r;
    logic            stall_r;

    logic            full_s;
    logic            grant_s;
    logic            deq_s;
    logic [NREQ-1:0] req_mask_s;
    logic [NREQ-1:0] pick_gnt_s;
    logic [PW-1:0]   pick_idx_s;
    logic [DW-1:0]   sel_data_s;
    logic [OW-1:0]   occ_next_s;
    logic [PW-1:0]   ptr_next_s;
    logic            unused_s;

    // q_full is informational; occupancy is tracked locally instead.
    assign unused_s = q_full;

    // Full is judged on the current count only, so a dequeue in the same
    // cycle cannot open a grant slot until the next cycle.
    assign full_s = (occ_r == OCC_FULL);

    // Mask all requests while full or in reset.
    always_comb begin
        if (rst || full_s) begin
            req_mask_s = {NREQ{1'b0}};
        end else begin
            req_mask_s = req;
        end
    end

    rr_pick #(
        .NREQ (NREQ),
        .PW   (PW)
    ) u_rr_pick (
        .req   (req_mask_s),
        .ptr   (rr_ptr_r),
        .gnt   (pick_gnt_s),
        .index (pick_idx_s)
    );

    assign grant_s = |pick_gnt_s;
    assign gnt     = pick_gnt_s;

    // Dequeue passes through only when the queue has something, never in reset.
    always_comb begin
        if (rst) begin
            deq_s = 1'b0;
        end else begin
            deq_s = c_deq && !q_empty;
        end
    end

    assign q_deq = deq_s;

    // One-hot AND-OR mux of the winning producer's payload.
    always_comb begin
        sel_data_s = {DW{1'b0}};
        for (int i = 0; i < NREQ; i++) begin
            sel_data_s = sel_data_s | (data[i*DW +: DW] & {DW{pick_gnt_s[i]}});
        end
    end

    // Occupancy: grant and dequeue in the same cycle cancel out.
    always_comb begin
        occ_next_s = occ_r;
        if (grant_s && !deq_s) begin
            occ_next_s = occ_r + OW'(1);
        end else if (deq_s && !grant_s && (occ_r != {OW{1'b0}})) begin
            occ_next_s = occ_r - OW'(1);
        end else begin
            occ_next_s = occ_r;
        end
    end

    // Pointer moves past the winner; it holds (including through a stall)
    // when nothing is granted.
    always_comb begin
        if (grant_s) begin
            if (pick_idx_s == PTR_LAST) begin
                ptr_next_s = {PW{1'b0}};
            end else begin
                ptr_next_s = pick_idx_s + PW'(1);
            end
        end else begin
            ptr_next_s = rr_ptr_r;
        end
    end

    // State and output registers; reset discards any in-flight enqueue.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr_r <= {PW{1'b0}};
            occ_r    <= {OW{1'b0}};
            q_enq_r  <= 1'b0;
            q_din_r  <= {DW{1'b0}};
            stall_r  <= 1'b0;
        end else begin
            rr_ptr_r <= ptr_next_s;
            occ_r    <= occ_next_s;
            q_enq_r  <= grant_s;
            stall_r  <= full_s;
            if (grant_s) begin
                q_din_r <= sel_data_s;
            end else begin
                q_din_r <= q_din_r;
            end
        end
    end

    assign q_enq = q_enq_r;
    assign q_din = q_din_r;
    assign occ   = occ_r;
    assign stall = stall_r;

endmodule

// File: tb/tb_queue_arb.sv
// tb_queue_arb: directed stimulus with a payload scoreboard for queue_arb.
// Stimulus pushes the expected payload of every expected grant; a negedge
// monitor pops and compares whenever q_enq is seen. A small counter models
// the downstream queue to drive q_empty/q_full.
module tb_queue_arb;

    localparam int NREQ  = 4;
    localparam int DW    = 32;
    localparam int DEPTH = 8;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic [NREQ-1:0]      req;
    logic [NREQ*DW-1:0]   data;
    logic [NREQ-1:0]      gnt;
    logic                 q_enq;
    logic [DW-1:0]        q_din;
    logic                 q_full;
    logic                 q_empty;
    logic                 c_deq;
    logic                 q_deq;
    logic [3:0]           occ;
    logic                 stall;

    int                   n_cmp = 0;
    int                   n_err = 0;
    int                   fcnt;
    int                   ngrant = 0;
    logic [DW-1:0]        exp_q[$];
    logic [DW-1:0]        last_din = 32'h0;

    queue_arb #(.NREQ(NREQ), .DW(DW), .DEPTH(DEPTH)) dut (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .data    (data),
        .gnt     (gnt),
        .q_enq   (q_enq),
        .q_din   (q_din),
        .q_full  (q_full),
        .q_empty (q_empty),
        .c_deq   (c_deq),
        .q_deq   (q_deq),
        .occ     (occ),
        .stall   (stall)
    );

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] pv(input int i);
        return 32'(i + 1) * 32'h1111_1111;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: actual %0h required %0h", nm, act, exp);
        end
    endtask

    // Downstream queue model: entry count, reset together with the arbiter.
    always @(posedge clk or posedge rst) begin
        if (rst) fcnt <= 0;
        else     fcnt <= fcnt + (q_enq ? 1 : 0) - (q_deq ? 1 : 0);
    end
    assign q_empty = (fcnt == 0);
    assign q_full  = (fcnt == DEPTH);

    // Monitor: compare every enqueue against the scoreboard, and check hold.
    always @(negedge clk) begin
        if (!rst) begin
            if (q_enq) begin
                chk("q_full_at_enq", 32'(q_full), 32'h0);
                if (exp_q.size() == 0) begin
                    chk("unexpected_enq", 32'(q_enq), 32'h0);
                end else begin
                    last_din = exp_q.pop_front();
                    chk("q_din", q_din, last_din);
                end
            end else begin
                chk("q_din_hold", q_din, last_din);
            end
        end
    end

    // One cycle: drive at posedge+1, check combinational and registered at +2.
    task automatic cyc(input string nm, input logic [3:0] r, input logic cd,
                       input logic [3:0] eg, input logic edq, input int eocc,
                       input logic est);
        req   = r;
        c_deq = cd;
        #1;
        chk({nm, ".gnt"},   32'(gnt),   32'(eg));
        chk({nm, ".q_deq"}, 32'(q_deq), 32'(edq));
        chk({nm, ".occ"},   32'(occ),   32'(eocc));
        chk({nm, ".stall"}, 32'(stall), 32'(est));
        for (int i = 0; i < NREQ; i++) begin
            if (eg[i]) exp_q.push_back(pv(i));
        end
        if (gnt != 4'b0000) ngrant++;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation exceeded time budget");
        $fatal(1, "timeout");
    end

    initial begin
        data  = {pv(3), pv(2), pv(1), pv(0)};
        req   = 4'b1111;
        c_deq = 1'b1;
        @(posedge clk);
        #1;
        // Reset state, with requests pending
        chk("rst.gnt",   32'(gnt),   32'h0);
        chk("rst.q_deq", 32'(q_deq), 32'h0);
        chk("rst.q_enq", 32'(q_enq), 32'h0);
        chk("rst.q_din", q_din,      32'h0);
        chk("rst.occ",   32'(occ),   32'h0);
        chk("rst.stall", 32'(stall), 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Dequeue while empty does nothing
        cyc("empty0", 4'b0000, 1'b1, 4'b0000, 1'b0, 0, 1'b0);
        // Round robin from reset, also dequeue attempts while queue empty
        cyc("rr1", 4'b1111, 1'b1, 4'b0001, 1'b0, 0, 1'b0);
        cyc("rr2", 4'b1111, 1'b1, 4'b0010, 1'b0, 1, 1'b0);
        cyc("rr3", 4'b1111, 1'b0, 4'b0100, 1'b0, 2, 1'b0);
        cyc("rr4", 4'b1111, 1'b0, 4'b1000, 1'b0, 3, 1'b0);
        cyc("rr5", 4'b1111, 1'b0, 4'b0001, 1'b0, 4, 1'b0);
        cyc("rr6", 4'b1111, 1'b0, 4'b0010, 1'b0, 5, 1'b0);
        cyc("rr7", 4'b1111, 1'b0, 4'b0100, 1'b0, 6, 1'b0);
        cyc("rr8", 4'b1111, 1'b0, 4'b1000, 1'b0, 7, 1'b0);
        // Full: no grant, stall one cycle later
        cyc("full9",  4'b1111, 1'b0, 4'b0000, 1'b0, 8, 1'b0);
        cyc("full10", 4'b1111, 1'b0, 4'b0000, 1'b0, 8, 1'b1);
        // Dequeue at full does not grant in the same cycle
        cyc("rel11", 4'b1111, 1'b1, 4'b0000, 1'b1, 8, 1'b1);
        // First grant after release follows the held pointer (0)
        cyc("rel12", 4'b1111, 1'b0, 4'b0001, 1'b0, 7, 1'b1);
        cyc("rel13", 4'b0000, 1'b0, 4'b0000, 1'b0, 8, 1'b0);
        // Drain to 3
        cyc("drn14", 4'b0000, 1'b1, 4'b0000, 1'b1, 8, 1'b1);
        cyc("drn15", 4'b0000, 1'b1, 4'b0000, 1'b1, 7, 1'b1);
        cyc("drn16", 4'b0000, 1'b1, 4'b0000, 1'b1, 6, 1'b0);
        cyc("drn17", 4'b0000, 1'b1, 4'b0000, 1'b1, 5, 1'b0);
        cyc("drn18", 4'b0000, 1'b1, 4'b0000, 1'b1, 4, 1'b0);
        // Grant (wrapping from pointer 1 to 0) and dequeue together: occ holds
        cyc("sim19", 4'b0001, 1'b1, 4'b0001, 1'b1, 3, 1'b0);
        // Skip: pointer 1, req 1001 -> 1000 then 0001
        cyc("skip20", 4'b1001, 1'b0, 4'b1000, 1'b0, 3, 1'b0);
        cyc("skip21", 4'b1001, 1'b0, 4'b0001, 1'b0, 4, 1'b0);

        // Reset mid-burst with an enqueue in flight
        req   = 4'b1111;
        c_deq = 1'b0;
        #1;
        chk("pre_rst.q_enq", 32'(q_enq), 32'h1);
        chk("pre_rst.occ",   32'(occ),   32'h5);
        rst = 1'b1;
        #1;
        chk("mid_rst.q_enq", 32'(q_enq), 32'h0);
        chk("mid_rst.q_din", q_din,      32'h0);
        chk("mid_rst.occ",   32'(occ),   32'h0);
        chk("mid_rst.stall", 32'(stall), 32'h0);
        chk("mid_rst.gnt",   32'(gnt),   32'h0);
        exp_q.delete();
        last_din = 32'h0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        cyc("post1", 4'b0100, 1'b0, 4'b0100, 1'b0, 0, 1'b0);
        cyc("post2", 4'b0000, 1'b0, 4'b0000, 1'b0, 1, 1'b0);

        // Second reset: pointer (3 here) must restart at 0
        rst = 1'b1;
        #1;
        chk("rst2.occ",   32'(occ), 32'h0);
        chk("rst2.q_din", q_din,    32'h0);
        exp_q.delete();
        last_din = 32'h0;
        @(posedge clk);
        #1;
        rst    = 1'b0;
        ngrant = 0;

        // Backpressure: exactly DEPTH grants, then blocked
        cyc("bp1", 4'b1001, 1'b0, 4'b0001, 1'b0, 0, 1'b0);
        for (int k = 1; k < DEPTH; k++) begin
            cyc("bp", 4'b0001, 1'b0, 4'b0001, 1'b0, k, 1'b0);
        end
        cyc("bp9",  4'b0001, 1'b0, 4'b0000, 1'b0, 8, 1'b0);
        cyc("bp10", 4'b0001, 1'b0, 4'b0000, 1'b0, 8, 1'b1);
        cyc("bp11", 4'b0001, 1'b0, 4'b0000, 1'b0, 8, 1'b1);
        chk("bp.grant_count", 32'(ngrant), 32'(DEPTH));
        cyc("idle", 4'b0000, 1'b0, 4'b0000, 1'b0, 8, 1'b1);
        chk("sb_drained", 32'(exp_q.size()), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/queue_arb.md
QUEUE_ARB -- requirements
Module: queue_arb

Interface
REQ-001 Parameter NREQ, default 4, number of producers.
REQ-002 Parameter DW, default 32, data width.
REQ-003 Parameter DEPTH, default 8, downstream queue capacity in entries.
REQ-004 clk  input  1  single clock; all state updates on posedge clk.
REQ-005 rst  input  1  reset, asynchronous, active-high.
REQ-006 req  input  NREQ  per-producer enqueue request, level.
REQ-007 data  input  NREQ*DW  producer payloads, producer i at bits [i*DW +: DW].
REQ-008 gnt  output  NREQ  one-hot grant, combinational; payload accepted at the edge ending the cycle.
REQ-009 q_enq  output  1  registered enqueue strobe to the queue.
REQ-010 q_din  output  DW  registered enqueue payload to the queue.
REQ-011 q_full  input  1  queue full flag, informational only.
REQ-012 q_empty  input  1  queue empty flag.
REQ-013 c_deq  input  1  consumer dequeue request.
REQ-014 q_deq  output  1  dequeue strobe to the queue, combinational.
REQ-015 occ  output  clog2(DEPTH+1)  tracked occupancy, including one in-flight enqueue.
REQ-016 stall  output  1  registered; high while occ == DEPTH.

Function
REQ-017 At most one gnt bit SHALL be high per cycle.
REQ-018 gnt SHALL be all-zero whenever occ == DEPTH, even if any req is high.
REQ-019 Winner SHALL be the first requester at or after rr_ptr, searching upward with modulo-NREQ wrap.
REQ-020 On a grant to index i, rr_ptr SHALL become (i+1) mod NREQ at the next edge; without a grant, rr_ptr holds.
REQ-021 A grant in cycle t SHALL produce q_enq=1 and q_din=data[i] in cycle t+1.
REQ-022 Without a grant in cycle t, q_enq SHALL be 0 in t+1 and q_din SHALL hold its last value.
REQ-023 q_deq SHALL equal c_deq AND NOT q_empty.
REQ-024 occ update rule:
- +1 on a grant only;
- -1 on q_deq only;
- unchanged when both occur in the same cycle.
REQ-025 occ SHALL never exceed DEPTH or fall below 0.
REQ-026 Because of REQ-018 and REQ-024, the queue SHALL never receive q_enq while holding DEPTH entries.
REQ-027 A q_full assertion while q_enq is high SHALL NOT occur; the bench flags it as an error.
REQ-028 stall SHALL rise the cycle after occ reaches DEPTH and fall the cycle after occ drops below DEPTH.
REQ-029 Release from stall: a simultaneous q_deq at occ == DEPTH SHALL NOT enable a grant in that same cycle.
REQ-030 The first grant after release SHALL follow the rr_ptr held during the stall.

Reset
REQ-031 While rst is high, all of the following SHALL be 0: q_enq, q_din, occ, stall, rr_ptr.
REQ-032 While rst is high, gnt and q_deq SHALL be forced to 0.
REQ-033 Reset mid-operation SHALL discard any in-flight enqueue.
REQ-034 The downstream queue SHALL be reset by the same reset event, inverted to its rstn, so that occ and the queue agree.
REQ-035 First grant is permitted in the first cycle after rst deasserts.

Structure
REQ-036 Package queue_arb_pkg SHALL hold:
- NREQ, DW, DEPTH defaults;
- OCC_W = clog2(DEPTH+1);
- typedef occ_t (OCC_W bits);
- typedef ptr_t (clog2(NREQ) bits).
REQ-037 The combinational round-robin search SHALL be the sub-module rr_pick, with inputs req and ptr and outputs one-hot gnt and index.
REQ-038 Occupancy, pointer and output registers SHALL reside in queue_arb.

Verification
REQ-039 Round-robin: req=4'b1111 held for 8 cycles from reset -> gnt sequence 0001,0010,0100,1000,0001,0010,0100,1000; q_din follows one cycle later.
REQ-040 Skip: rr_ptr=1, req=4'b1001 -> gnt=4'b1000, then 4'b0001.
REQ-041 Backpressure: DEPTH=8, req=4'b0001 held, c_deq=0 -> exactly 8 grants, occ=8, stall=1 from the next cycle, gnt=0 thereafter, q_full never coincides with q_enq.
REQ-042 Simultaneous events: occ=3, grant and q_deq in the same cycle -> occ stays 3; at occ=8, c_deq=1 with q_empty=0 -> occ=7 and a grant in the following cycle.
REQ-043 Empty: q_empty=1, c_deq=1 -> q_deq=0, occ unchanged.
REQ-044 Reset mid-burst: rst pulsed while q_enq=1 and occ=5 -> outputs 0 asynchronously; after release, req=4'b0100 -> first grant 4'b0100 with rr_ptr starting at 0.
